// File: rtl/dmax_scroll_ctrl.sv
// Scroll sequencer: streams message columns to the dot-matrix display at device 16'h0040 over a shared, arbitrated bus.
// Define DMAX_SCROLL_LOOP_EN to wrap the message continuously instead of a single pass followed by blank columns.
module dmax_scroll_ctrl #(
    parameter int DEPTH      = 64,
    parameter int AW         = 6,
    parameter int BLANK_COLS = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [6:0]    cfg_data,
    input  logic [AW:0]   msg_len,
    input  logic [15:0]   rate,
    input  logic          start,
    input  logic          stop,
    input  logic          bus_gnt,
    output logic          bus_req,
    output logic [15:0]   DEVICE,
    output logic [15:0]   DATA,
    output logic          busy,
    output logic          done
);

    // state   | meaning
    // IDLE    | no pass in progress, bus released
    // WAIT    | counting rate cycles before the next step
    // REQ     | bus_req high, waiting for bus_gnt
    // WRITE   | one-cycle column shift-in on DEVICE/DATA
    // RELEASE | bus dropped, index / blank count advanced
    // BLANK   | encoded but never entered; blank_q routes blank columns through WAIT/REQ/WRITE
    typedef enum logic [2:0] {IDLE, WAIT, REQ, WRITE, RELEASE, BLANK} state_e;

    localparam logic [15:0] DEV_ADDR  = 16'h0040;
    localparam logic [4:0]  CMD_SHIFT = 5'b00001;

    state_e        state_q;
    logic [6:0]    msg_mem_q [DEPTH];
    logic [AW-1:0] index_q;
    logic [AW:0]   len_q;
    logic [15:0]   rate_q;
    logic [15:0]   cnt_q;
    logic          stop_q;
    logic          bus_req_q;
    logic [15:0]   device_q;
    logic [15:0]   data_q;
    logic          busy_q;
    logic          done_q;
    logic          idx_last;
    logic          last_col;
    logic [6:0]    col;

`ifndef DMAX_SCROLL_LOOP_EN
    localparam int BW = $clog2(BLANK_COLS + 1);
    logic          blank_q;
    logic [BW-1:0] bcnt_q;
`endif

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            msg_mem_q[cfg_addr] <= cfg_data;
        end
    end

    assign idx_last = ({1'b0, index_q} == (len_q - 1'b1));

`ifdef DMAX_SCROLL_LOOP_EN
    assign last_col = idx_last;
    assign col      = msg_mem_q[index_q];
`else
    assign last_col = blank_q && (bcnt_q == BW'(BLANK_COLS - 1));
    assign col      = blank_q ? 7'h00 : msg_mem_q[index_q];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            index_q   <= '0;
            len_q     <= '0;
            rate_q    <= '0;
            cnt_q     <= '0;
            stop_q    <= 1'b0;
            bus_req_q <= 1'b0;
            device_q  <= 16'h0000;
            data_q    <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifndef DMAX_SCROLL_LOOP_EN
            blank_q   <= 1'b0;
            bcnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop && (msg_len != '0)) begin
                        len_q   <= msg_len;
                        rate_q  <= (rate == 16'd0) ? 16'd1 : rate;
                        index_q <= '0;
                        cnt_q   <= '0;
                        stop_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
`ifndef DMAX_SCROLL_LOOP_EN
                        blank_q <= 1'b0;
                        bcnt_q  <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == rate_q - 16'd1) begin
                        cnt_q     <= '0;
                        bus_req_q <= 1'b1;
                        state_q   <= REQ;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                REQ: begin
                    if (stop) begin
                        bus_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (bus_gnt) begin
                        device_q <= DEV_ADDR;
                        data_q   <= {CMD_SHIFT, 4'b0000, col};
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    // Grant loss here is ignored: the write has already been presented.
                    bus_req_q <= 1'b0;
                    device_q  <= 16'h0000;
                    data_q    <= 16'h0000;
                    stop_q    <= stop;
                    done_q    <= last_col && !stop;
                    state_q   <= RELEASE;
                end
                RELEASE: begin
                    if (stop_q || stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
`ifdef DMAX_SCROLL_LOOP_EN
                        index_q <= idx_last ? '0 : index_q + 1'b1;
                        state_q <= WAIT;
`else
                        if (blank_q) begin
                            if (last_col) begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                bcnt_q  <= bcnt_q + 1'b1;
                                state_q <= WAIT;
                            end
                        end else begin
                            if (idx_last) begin
                                blank_q <= 1'b1;
                                bcnt_q  <= '0;
                            end else begin
                                index_q <= index_q + 1'b1;
                            end
                            state_q <= WAIT;
                        end
`endif
                    end
                end
                default: begin
                    bus_req_q <= 1'b0;
                    device_q  <= 16'h0000;
                    data_q    <= 16'h0000;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus_req = bus_req_q;
    assign DEVICE  = device_q;
    assign DATA    = data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dmax_scroll_ctrl.sv
// Directed testbench for dmax_scroll_ctrl: pass sequencing, spacing, grant stall, stop and reset handling.
module tb_dmax_scroll_ctrl;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [6:0]    cfg_data;
    logic [AW:0]   msg_len;
    logic [15:0]   rate;
    logic          start;
    logic          stop;
    logic          bus_gnt;
    logic          bus_req;
    logic [15:0]   DEVICE;
    logic [15:0]   DATA;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    dmax_scroll_ctrl #(.DEPTH(64), .AW(AW), .BLANK_COLS(30)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .msg_len(msg_len), .rate(rate), .start(start), .stop(stop), .bus_gnt(bus_gnt),
        .bus_req(bus_req), .DEVICE(DEVICE), .DATA(DATA), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; msg_len = '0;
        rate = '0; start = 1'b0; stop = 1'b0; bus_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus_req, busy, done} !== 3'b000 || DEVICE !== 16'h0000 || DATA !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: bus_req=%b busy=%b done=%b DEVICE=%h DATA=%h, required all 0",
                     bus_req, busy, done, DEVICE, DATA);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic load_buffer();
        logic [6:0] cols [3];
        cols = '{7'h7F, 7'h41, 7'h7F};
        for (int i = 0; i < 3; i++) begin
            cfg_we = 1'b1; cfg_addr = 6'(i); cfg_data = cols[i];
            step();
        end
        cfg_we = 1'b0;
    endtask

`ifndef DMAX_SCROLL_LOOP_EN
    task automatic test_pass();
        logic [15:0] exp_tab [3];
        logic [15:0] exp;
        int c, nw, nd, last_w, first_c, done_c, sp_bad, idle_bad;
        bit ended;
        exp_tab = '{16'h087F, 16'h0841, 16'h087F};
        c = 0; nw = 0; nd = 0; last_w = -1; first_c = -1; done_c = -1;
        sp_bad = 0; idle_bad = 0; ended = 0;
        msg_len = 7'd3; rate = 16'd4; bus_gnt = 1'b1;
        pulse_start();
        while (c < 400 && !ended) begin
            // a second start mid-pass with other settings must be ignored
            if (c == 10) begin start = 1'b1; msg_len = 7'd5; rate = 16'd9; end
            else start = 1'b0;
            step();
            c++;
            if (DEVICE === 16'h0040) begin
                exp = (nw < 3) ? exp_tab[nw] : 16'h0800;
                checks++;
                if (DATA !== exp) begin
                    failures++;
                    $display("FAIL pass_data[%0d]: DATA=%h required %h", nw, DATA, exp);
                end
                if (nw == 0) first_c = c;
                else if (c - last_w != 7) sp_bad++;
                last_w = c;
                nw++;
            end else if (DEVICE !== 16'h0000 || DATA !== 16'h0000) begin
                idle_bad++;
            end
            if (done === 1'b1) begin nd++; done_c = c; end
            if (busy === 1'b0) ended = 1;
        end
        start = 1'b0; msg_len = 7'd3; rate = 16'd4;
        checks++;
        if (!ended) begin failures++; $display("FAIL pass_timeout: busy still %b after %0d cycles, required 0", busy, c); end
        checks++;
        if (nw != 33) begin failures++; $display("FAIL pass_write_count: got %0d writes, required 33", nw); end
        checks++;
        if (nd != 1) begin failures++; $display("FAIL pass_done_count: got %0d done pulses, required 1", nd); end
        checks++;
        if (first_c != 5) begin failures++; $display("FAIL pass_first_latency: first write at cycle %0d, required 5", first_c); end
        checks++;
        if (sp_bad != 0) begin failures++; $display("FAIL pass_spacing: %0d gaps differ, required all 7", sp_bad); end
        checks++;
        if (idle_bad != 0) begin failures++; $display("FAIL pass_bus_idle: %0d non-write cycles drove bus, required 0", idle_bad); end
        checks++;
        if (done_c != last_w + 1) begin failures++; $display("FAIL pass_done_timing: done at %0d, required %0d", done_c, last_w + 1); end
        checks++;
        if (bus_req !== 1'b0) begin failures++; $display("FAIL pass_end_req: bus_req=%b required 0", bus_req); end
    endtask
`else
    task automatic test_loop();
        logic [15:0] exp;
        int nw, nd, last_w, done_bad, blank_w;
        nw = 0; nd = 0; last_w = -10; done_bad = 0; blank_w = 0;
        msg_len = 7'd2; rate = 16'd4; bus_gnt = 1'b1;
        pulse_start();
        for (int c = 1; c <= 60; c++) begin
            step();
            if (DEVICE === 16'h0040) begin
                exp = (nw % 2 == 1) ? 16'h0841 : 16'h087F;
                checks++;
                if (DATA !== exp) begin
                    failures++;
                    $display("FAIL loop_data[%0d]: DATA=%h required %h", nw, DATA, exp);
                end
                if (DATA === 16'h0800) blank_w++;
                nw++;
                last_w = c;
            end
            if (done === 1'b1) begin
                nd++;
                if (c != last_w + 1 || nw % 2 != 0) done_bad++;
            end
        end
        checks++;
        if (nw != 8 || nd != 4) begin failures++; $display("FAIL loop_counts: writes=%0d done=%0d, required 8 and 4", nw, nd); end
        checks++;
        if (done_bad != 0 || blank_w != 0) begin failures++; $display("FAIL loop_done_blank: misplaced done=%0d blank writes=%0d, required 0 and 0", done_bad, blank_w); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL loop_still_busy: busy=%b required 1", busy); end
        stop = 1'b1; step(); stop = 1'b0;
        step(); step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL loop_stop: busy=%b required 0", busy); end
        msg_len = 7'd3;
    endtask
`endif

    task automatic test_stop_write();
        int c, nw, extra_w, extra_d, extra_b;
        c = 0; nw = 0; extra_w = 0; extra_d = 0; extra_b = 0;
        msg_len = 7'd3; rate = 16'd4; bus_gnt = 1'b1;
        pulse_start();
        while (c < 60 && nw < 2) begin
            step();
            c++;
            if (DEVICE === 16'h0040) nw++;
        end
        checks++;
        if (nw != 2) begin failures++; $display("FAIL stopw_reach: saw %0d writes, required 2", nw); end
        checks++;
        if (DATA !== 16'h0841) begin failures++; $display("FAIL stopw_data: DATA=%h required 0841", DATA); end
        stop = 1'b1; step(); stop = 1'b0;
        checks++;
        if (busy !== 1'b1 || DEVICE !== 16'h0000 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL stopw_release: busy=%b DEVICE=%h bus_req=%b, required 1 0000 0", busy, DEVICE, bus_req);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL stopw_idle: busy=%b required 0", busy); end
        for (int i = 0; i < 40; i++) begin
            step();
            if (DEVICE !== 16'h0000) extra_w++;
            if (done !== 1'b0) extra_d++;
            if (busy !== 1'b0) extra_b++;
        end
        checks++;
        if (extra_w + extra_d + extra_b != 0) begin
            failures++;
            $display("FAIL stopw_after: writes=%0d done=%0d busy=%0d, required 0 0 0", extra_w, extra_d, extra_b);
        end
    endtask

    task automatic test_gnt_stall();
        bit got;
        int bad;
        msg_len = 7'd3; rate = 16'd4; bus_gnt = 1'b0;
        pulse_start();
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (bus_req === 1'b1) got = 1; else step();
        end
        checks++;
        if (!got) begin failures++; $display("FAIL stall_req_timeout: bus_req=%b required 1", bus_req); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_req !== 1'b1 || DEVICE !== 16'h0000 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_hold: %0d cycles with wrong req/bus, required 0", bad); end
        bus_gnt = 1'b1;
        step();
        checks++;
        if (DEVICE !== 16'h0040 || DATA !== 16'h087F) begin
            failures++;
            $display("FAIL stall_write: DEVICE=%h DATA=%h required 0040 087F", DEVICE, DATA);
        end
        bus_gnt = 1'b0;
        step();
        checks++;
        if (bus_req !== 1'b0 || DEVICE !== 16'h0000 || DATA !== 16'h0000) begin
            failures++;
            $display("FAIL stall_release: bus_req=%b DEVICE=%h DATA=%h required 0 0000 0000", bus_req, DEVICE, DATA);
        end
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (bus_req === 1'b1) got = 1; else step();
        end
        stop = 1'b1; step(); stop = 1'b0;
        checks++;
        if (!got || busy !== 1'b0 || bus_req !== 1'b0 || done !== 1'b0 || DEVICE !== 16'h0000) begin
            failures++;
            $display("FAIL stall_stop_req: reached=%0d busy=%b bus_req=%b done=%b DEVICE=%h, required 1 0 0 0 0000",
                     got, busy, bus_req, done, DEVICE);
        end
    endtask

    task automatic test_rate_zero();
        int c, nw, w0, w1;
        c = 0; nw = 0; w0 = -1; w1 = -1;
        msg_len = 7'd3; rate = 16'd0; bus_gnt = 1'b1;
        pulse_start();
        while (c < 40 && nw < 2) begin
            step();
            c++;
            if (DEVICE === 16'h0040) begin
                if (nw == 0) w0 = c; else w1 = c;
                nw++;
            end
        end
        checks++;
        if (w0 != 2 || w1 != 6) begin failures++; $display("FAIL rate0_timing: writes at %0d,%0d required 2,6", w0, w1); end
        checks++;
        if (DATA !== 16'h0841) begin failures++; $display("FAIL rate0_data: DATA=%h required 0841", DATA); end
        step(); step();
        stop = 1'b1; step(); stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL rate0_stop_wait: busy=%b bus_req=%b required 0 0", busy, bus_req);
        end
        rate = 16'd4;
    endtask

    task automatic test_reset_req();
        bit got;
        msg_len = 7'd3; rate = 16'd4; bus_gnt = 1'b0;
        pulse_start();
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (bus_req === 1'b1) got = 1; else step();
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (!got || bus_req !== 1'b0 || busy !== 1'b0 || DEVICE !== 16'h0000 || DATA !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset: reached=%0d bus_req=%b busy=%b DEVICE=%h DATA=%h, required 1 0 0 0000 0000",
                     got, bus_req, busy, DEVICE, DATA);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        msg_len = 7'd0;
        pulse_start();
        step();
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_start: busy=%b bus_req=%b required 0 0", busy, bus_req);
        end
        msg_len = 7'd3;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        repeat (6) step();
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0 || DEVICE !== 16'h0000) begin
            failures++;
            $display("FAIL start_stop_same: busy=%b bus_req=%b DEVICE=%h required 0 0 0000", busy, bus_req, DEVICE);
        end
    endtask

    initial begin
        test_reset();
        load_buffer();
`ifdef DMAX_SCROLL_LOOP_EN
        test_loop();
`else
        test_pass();
`endif
        test_stop_write();
        test_gnt_stall();
        test_rate_zero();
        test_reset_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
